md_unit: RTL

- Multiply/divide unit in the execute stage of the P6 pipeline.
- Consumes the 4-bit start code and HLSel produced by the instruction decoder, plus the forwarded rs/rt operands.
- Owns the HI/LO registers and models multi-cycle mult/div latency through a busy counter.
- Reports busy so hazard logic can stall later mult/div/mfhi/mflo/mthi/mtlo instructions in the decode stage.

---
 rtl/md_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- execute-stage multiply/divide unit with HI/LO registers.
//
// Starts signed/unsigned mult and div, holds each result in pending registers
// for a fixed latency, then commits it to HI/LO. Also handles mthi/mtlo
// writes and provides a combinational HI/LO read port.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous active-high reset (HI, LO, busy, counter)
//   start  in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo,
//                   7 mthi, 8 mtlo, 9-15 none
//   HLSel  in   1   read select: 1 = HI, 0 = LO
//   A      in  32   rs operand (dividend / multiplicand / mthi-mtlo data)
//   B      in  32   rt operand (divisor / multiplier)
//   busy   out  1   high while a mult/div is in flight (registered)
//   HLout  out 32   HLSel ? HI : LO, committed values only
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  start,
    input  logic        HLSel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HLout
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [31:0]        hi_r, hi_s;
    logic [31:0]        lo_r, lo_s;
    logic [31:0]        hi_pend_r, hi_pend_s;
    logic [31:0]        lo_pend_r, lo_pend_s;
    logic               commit_r, commit_s;   // 0 for divide-by-zero: HI/LO kept
    logic               busy_r;

    // Arithmetic datapath, evaluated on the current operands; only used
    // at the start edge, so later operand changes do not matter.
    logic signed [63:0] smul_s;
    logic        [63:0] umul_s;
    logic        [31:0] abs_a_s, abs_b_s, udivisor_s;
    logic        [31:0] squo_mag_s, srem_mag_s, squo_s, srem_s;
    logic        [31:0] uquo_s, urem_s;

    assign smul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign umul_s = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes; this also yields 0x80000000 / -1 =
    // 0x80000000 with remainder 0 without a special case. A zero divisor is
    // replaced by 1 so the datapath stays defined; its result is never committed.
    assign abs_a_s    = A[31] ? (32'd0 - A) : A;
    assign abs_b_s    = (B == 32'd0) ? 32'd1 : (B[31] ? (32'd0 - B) : B);
    assign udivisor_s = (B == 32'd0) ? 32'd1 : B;
    assign squo_mag_s = abs_a_s / abs_b_s;
    assign srem_mag_s = abs_a_s % abs_b_s;
    assign squo_s     = (A[31] ^ B[31]) ? (32'd0 - squo_mag_s) : squo_mag_s;
    assign srem_s     = A[31] ? (32'd0 - srem_mag_s) : srem_mag_s;
    assign uquo_s     = A / udivisor_s;
    assign urem_s     = A % udivisor_s;

    // Next-state, counter, pending-result and HI/LO update logic.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        hi_pend_s = hi_pend_r;
        lo_pend_s = lo_pend_r;
        commit_s  = commit_r;
        case (state_r)
            ST_IDLE: begin
                case (start)
                    4'd1: begin
                        hi_pend_s = smul_s[63:32];
                        lo_pend_s = smul_s[31:0];
                        commit_s  = 1'b1;
                        cnt_s     = CNT_W'(MULT_CYCLES);
                        state_s   = ST_RUN;
                    end
                    4'd2: begin
                        hi_pend_s = umul_s[63:32];
                        lo_pend_s = umul_s[31:0];
                        commit_s  = 1'b1;
                        cnt_s     = CNT_W'(MULT_CYCLES);
                        state_s   = ST_RUN;
                    end
                    4'd3: begin
                        hi_pend_s = srem_s;
                        lo_pend_s = squo_s;
                        commit_s  = (B != 32'd0);
                        cnt_s     = CNT_W'(DIV_CYCLES);
                        state_s   = ST_RUN;
                    end
                    4'd4: begin
                        hi_pend_s = urem_s;
                        lo_pend_s = uquo_s;
                        commit_s  = (B != 32'd0);
                        cnt_s     = CNT_W'(DIV_CYCLES);
                        state_s   = ST_RUN;
                    end
                    4'd7: begin
                        hi_s = A;
                    end
                    4'd8: begin
                        lo_s = A;
                    end
                    default: begin
                        // none, mfhi, mflo and unused codes leave state alone
                        state_s = ST_IDLE;
                    end
                endcase
            end
            ST_RUN: begin
                // Every start code is ignored here; the decoder stalls instead.
                if (cnt_r == CNT_W'(1)) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_IDLE;
                    if (commit_r) begin
                        hi_s = hi_pend_r;
                        lo_s = lo_pend_r;
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, HI/LO and pending registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            hi_pend_r <= 32'd0;
            lo_pend_r <= 32'd0;
            commit_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            hi_pend_r <= hi_pend_s;
            lo_pend_r <= lo_pend_s;
            commit_r  <= commit_s;
            busy_r    <= (state_s == ST_RUN);
        end
    end

    assign busy  = busy_r;
    assign HLout = HLSel ? hi_r : lo_r;

endmodule
